// File: rtl/mips_pkg.sv
// Shared types and constants for the mips front end.
package mips_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ADDR_W  = 32;

    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [0:0] {
        RUN,
        KILL
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer between fetch and decode; flush wins over push and pop.
module fetch_fifo
    import mips_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  fetch_entry_t             push_data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output fetch_entry_t             head_o,
    output logic                     valid_o,
    output logic [$clog2(Depth):0]   count_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    fetch_entry_t    mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            do_pop;

    assign do_pop = pop_i && (count_q != '0);

    // Depth is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CntW'(push_i) - CntW'(do_pop);
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

    push_has_room: assert property (@(posedge clk_i) disable iff (rst_i)
        (push_i && !flush_i) |-> (count_q < CntW'(Depth)));

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: program counter, req/ack issue logic and redirect handling.
module instr_fetch
    import mips_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned       FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               instr_ready
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t      state_q;
    logic [ADDR_W-1:0] fetch_pc_q;
    logic [ADDR_W-1:0] kill_pc_q;
    logic              req_q;

    logic              ack_fire;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] redirect_tgt;
    logic [CntW-1:0]   count;
    logic [CntW-1:0]   count_next;
    fetch_entry_t      head;
    fetch_entry_t      push_entry;

    assign ack_fire     = imem_ack && req_q;
    assign push         = ack_fire && (state_q == RUN) && !redirect_valid;
    assign pop          = instr_valid && instr_ready;
    assign redirect_tgt = redirect_pc & {{(ADDR_W-2){1'b1}}, 2'b00};
    assign push_entry   = '{instr: imem_rdata, pc: fetch_pc_q};

    always_comb begin
        count_next = '0;
        if (!redirect_valid) begin
            count_next = count + CntW'(push) - CntW'(pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            fetch_pc_q <= RESET_PC;
            kill_pc_q  <= RESET_PC;
            req_q      <= 1'b0;
        end else begin
            if (redirect_valid) begin
                if (!req_q || ack_fire) begin
                    state_q    <= RUN;
                    fetch_pc_q <= redirect_tgt;
                end else begin
                    state_q   <= KILL;
                    kill_pc_q <= redirect_tgt;
                end
            end else if (ack_fire) begin
                state_q    <= RUN;
                fetch_pc_q <= (state_q == KILL) ? kill_pc_q : fetch_pc_q + ADDR_W'(4);
            end
            // With nothing left outstanding the FSM is back in RUN, so only room matters.
            req_q <= (req_q && !ack_fire) || (count_next < CntW'(FIFO_DEPTH));
        end
    end

    fetch_fifo #(
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk),
        .rst_i       (reset),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .flush_i     (redirect_valid),
        .head_o      (head),
        .valid_o     (instr_valid),
        .count_o     (count)
    );

    assign imem_req  = req_q;
    assign imem_addr = fetch_pc_q;
    assign instr     = head.instr;
    assign instr_pc  = head.pc;

endmodule
